heq_map_divider: RTL and testbench

Parametrised histogram-equalisation mapping unit. Computes g = round_or_trunc(((cdf_in − cdf_min) × (2^PIX_W − 1)) / (num_pixels − cdf_min)) with a bit-serial restoring divider. Sits between the CDF accumulator and the output LUT writer. Replaces the fixed 8-bit, fixed-CDFMIN, fixed-SIZE divider path with:

- run-time cdf_min and num_pixels,
- a valid/ready handshake on both sides,
- clamping, saturation and divide-by-zero handling.

---
 rtl/heq_map_divider.sv | 174 +++++++++++++++++
 tb/tb_heq_map_divider.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/heq_map_divider.sv
// heq_map_divider
// Histogram-equalisation mapping unit. For each request it computes
//   g = ((cdf_in - cdf_min) * (2^PIX_W - 1)) / (num_pixels - cdf_min)
// using a bit-serial restoring divider (one quotient bit per clock).
// It clamps out-of-range quotients and short-circuits zero numerators and
// zero denominators.
//
// Build option: define HEQ_ROUND_EN to round half-up by adding D/2 to the
// numerator before dividing. Leave it undefined for truncating division.
// Latency is the same in both builds.
//
// Ports
//   clk_i, reset_i   : clock (rising edge) and synchronous active-high reset
//   in_valid_i       : request valid
//   in_ready_o       : block can accept a request (IDLE only)
//   cdf_in_i         : cumulative count of the current bin
//   cdf_min_i        : smallest non-zero CDF value
//   num_pixels_i     : total pixel count
//   out_valid_o      : result valid, held until out_ready_i
//   out_ready_i      : consumer accepts the result
//   g_out_o          : mapped grey level
//   sat_o            : quotient exceeded 2^PIX_W-1 and was clamped
//   div_zero_o       : denominator was zero
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// DIV   | one restoring-division step per cycle
// DONE  | result presented, waiting for out_ready
module heq_map_divider #(
    parameter int CDF_W = 16,
    parameter int PIX_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [CDF_W-1:0] cdf_in_i,
    input  logic [CDF_W-1:0] cdf_min_i,
    input  logic [CDF_W-1:0] num_pixels_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [PIX_W-1:0] g_out_o,
    output logic             sat_o,
    output logic             div_zero_o
);
    localparam int NUM_W = CDF_W + PIX_W;
    localparam int CNT_W = $clog2(NUM_W);
    localparam logic [PIX_W-1:0] G_MAX = '1;

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             sat_q;
    logic             div_zero_q;
    logic [PIX_W-1:0] g_q;
    // Dividend bits are shifted out of the top while quotient bits are
    // shifted in at the bottom, so one register holds both.
    logic [NUM_W-1:0] numq_q;
    logic [NUM_W-1:0] rem_q;
    logic [NUM_W:0]   den_q;
    logic [CNT_W-1:0] cnt_q;

    logic [CDF_W-1:0] diff_d;
    logic [CDF_W-1:0] den_d;
    logic [NUM_W-1:0] scaled_d;
    logic [NUM_W:0]   num_d;
    logic [NUM_W:0]   rem_sh_d;
    logic             q_bit_d;
    logic [NUM_W-1:0] rem_d;
    logic [NUM_W-1:0] quot_d;
    logic             quot_hi_d;

    // Operand preparation, only consumed in the accept cycle.
    always_comb begin
        diff_d   = (cdf_in_i < cdf_min_i) ? '0 : cdf_in_i - cdf_min_i;
        den_d    = (num_pixels_i < cdf_min_i) ? '0 : num_pixels_i - cdf_min_i;
        // diff * (2^PIX_W - 1) without a multiplier
        scaled_d = {diff_d, {PIX_W{1'b0}}} - {{PIX_W{1'b0}}, diff_d};
`ifdef HEQ_ROUND_EN
        num_d    = {1'b0, scaled_d} + {{(PIX_W+1){1'b0}}, den_d >> 1};
`else
        num_d    = {1'b0, scaled_d};
`endif
    end

    // One restoring step.
    always_comb begin
        rem_sh_d  = {rem_q, numq_q[NUM_W-1]};
        q_bit_d   = (rem_sh_d >= den_q);
        rem_d     = q_bit_d ? NUM_W'(rem_sh_d - den_q) : rem_sh_d[NUM_W-1:0];
        quot_d    = {numq_q[NUM_W-2:0], q_bit_d};
        quot_hi_d = |quot_d[NUM_W-1:PIX_W];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            g_q         <= '0;
            sat_q       <= 1'b0;
            div_zero_q  <= 1'b0;
            numq_q      <= '0;
            rem_q       <= '0;
            den_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid_i && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        sat_q      <= 1'b0;
                        div_zero_q <= 1'b0;
                        if (den_d == '0) begin
                            g_q         <= G_MAX;
                            div_zero_q  <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else if (diff_d == '0) begin
                            g_q         <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            numq_q  <= num_d[NUM_W-1:0];
                            // With rounding the dividend can carry into bit NUM_W.
                            // That bit seeds the remainder. D >= 2 whenever it is
                            // set, so the quotient still fits in NUM_W bits.
                            rem_q   <= {{(NUM_W-1){1'b0}}, num_d[NUM_W]};
                            den_q   <= {{(PIX_W+1){1'b0}}, den_d};
                            cnt_q   <= CNT_W'(NUM_W - 1);
                            state_q <= DIV;
                        end
                    end
                end
                DIV: begin
                    numq_q <= quot_d;
                    rem_q  <= rem_d;
                    if (cnt_q == '0) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                        if (quot_hi_d) begin
                            g_q   <= G_MAX;
                            sat_q <= 1'b1;
                        end else begin
                            g_q <= quot_d[PIX_W-1:0];
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign g_out_o     = g_q;
    assign sat_o       = sat_q;
    assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_heq_map_divider.sv
module tb_heq_map_divider;
    localparam int CDF_W  = 16;
    localparam int PIX_W  = 8;
    localparam int NUM_W  = CDF_W + PIX_W;
    localparam int CDF_W2 = 12;
    localparam int PIX_W2 = 10;
    localparam int NUM_W2 = CDF_W2 + PIX_W2;
`ifdef HEQ_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic in_valid, in_ready, out_valid, out_ready, sat, div_zero;
    logic [CDF_W-1:0] cdf_in, cdf_min, num_pixels;
    logic [PIX_W-1:0] g_out;

    logic in_valid_b, in_ready_b, out_valid_b, out_ready_b, sat_b, div_zero_b;
    logic [CDF_W2-1:0] cdf_in_b, cdf_min_b, num_pixels_b;
    logic [PIX_W2-1:0] g_out_b;

    int n_tests = 0;
    int n_fail  = 0;

    heq_map_divider #(.CDF_W(CDF_W), .PIX_W(PIX_W)) dut (
        .clk_i(clk), .reset_i(reset),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .cdf_in_i(cdf_in), .cdf_min_i(cdf_min), .num_pixels_i(num_pixels),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .g_out_o(g_out), .sat_o(sat), .div_zero_o(div_zero)
    );

    heq_map_divider #(.CDF_W(CDF_W2), .PIX_W(PIX_W2)) dut_b (
        .clk_i(clk), .reset_i(reset),
        .in_valid_i(in_valid_b), .in_ready_o(in_ready_b),
        .cdf_in_i(cdf_in_b), .cdf_min_i(cdf_min_b), .num_pixels_i(num_pixels_b),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready_b),
        .g_out_o(g_out_b), .sat_o(sat_b), .div_zero_o(div_zero_b)
    );

    // Reference: straight arithmetic on the mapping formula.
    task automatic model(input longint cin, input longint cmin, input longint np,
                         input int pixw, output longint g, output bit s,
                         output bit dz, output bit short_c);
        longint diff, d, n, q, mx;
        mx = (longint'(1) << pixw) - 1;
        diff = (cin < cmin) ? 0 : cin - cmin;
        d = (np < cmin) ? 0 : np - cmin;
        s = 1'b0; dz = 1'b0; short_c = 1'b0;
        if (d == 0) begin
            g = mx; dz = 1'b1; short_c = 1'b1;
        end else if (diff == 0) begin
            g = 0; short_c = 1'b1;
        end else begin
            n = diff * mx + (ROUND ? d / 2 : 0);
            q = n / d;
            if (q > mx) begin g = mx; s = 1'b1; end
            else g = q;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (!in_ready && k < 100) begin step(); k++; end
        check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    endtask

    // One full request on the default instance; hold = cycles out_ready stays
    // low after out_valid, during which a competing request is presented.
    task automatic txn_a(input int cin, input int cmin, input int np,
                         input int hold, input string tag);
        longint eg; bit es, edz, esc; int lat;
        model(cin, cmin, np, PIX_W, eg, es, edz, esc);
        wait_ready(tag);
        in_valid = 1'b1; cdf_in = 16'(cin); cdf_min = 16'(cmin); num_pixels = 16'(np);
        out_ready = (hold == 0);
        step();
        in_valid = 1'b0;
        cdf_in = 16'($urandom); cdf_min = 16'($urandom); num_pixels = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin step(); lat++; end
        check({tag, "_lat"}, 64'(lat), esc ? 64'd1 : 64'(NUM_W + 1));
        check({tag, "_g"}, 64'(g_out), 64'(eg));
        check({tag, "_sat"}, 64'(sat), 64'(es));
        check({tag, "_dz"}, 64'(div_zero), 64'(edz));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            cdf_in = 16'($urandom); cdf_min = 16'($urandom_range(0, 3));
            num_pixels = 16'($urandom);
            step();
            check({tag, "_hold_g"}, 64'(g_out), 64'(eg));
            check({tag, "_hold_v"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check({tag, "_post_v"}, 64'(out_valid), 64'd0);
        check({tag, "_post_rdy"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint eg; bit es, edz, esc; int lat; int np, cmin, cin, sel;

        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        cdf_in = '0; cdf_min = '0; num_pixels = '0;
        in_valid_b = 1'b0; out_ready_b = 1'b1;
        cdf_in_b = '0; cdf_min_b = '0; num_pixels_b = '0;
        repeat (3) step();
        check("rst_rdy", 64'(in_ready), 64'd0);
        check("rst_v", 64'(out_valid), 64'd0);
        check("rst_g", 64'(g_out), 64'd0);
        check("rst_sat", 64'(sat), 64'd0);
        check("rst_dz", 64'(div_zero), 64'd0);
        reset = 1'b0;
        step();
        check("rst_rdy_after", 64'(in_ready), 64'd1);

        txn_a(33, 1, 64, 0, "basic");
        txn_a(64, 1, 64, 0, "full");
        txn_a(100, 1, 64, 0, "satur");
        txn_a(0, 1, 64, 0, "zero_num");
        txn_a(9, 5, 5, 0, "div_zero");
        txn_a(9, 7, 3, 0, "np_lt_min");
        txn_a(500, 10, 1000, 10, "backpr");
        txn_a(33, 1, 64, 0, "after_bp");

        // Reset in the middle of a division.
        wait_ready("mid_rst");
        in_valid = 1'b1; cdf_in = 16'd33; cdf_min = 16'd1; num_pixels = 16'd64;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        check("mid_rst_busy_v", 64'(out_valid), 64'd0);
        reset = 1'b1;
        step();
        check("mid_rst_v", 64'(out_valid), 64'd0);
        check("mid_rst_g", 64'(g_out), 64'd0);
        check("mid_rst_rdy", 64'(in_ready), 64'd0);
        reset = 1'b0;
        step();
        check("mid_rst_rdy_after", 64'(in_ready), 64'd1);
        check("mid_rst_v_after", 64'(out_valid), 64'd0);
        repeat (NUM_W + 3) begin
            step();
            check("mid_rst_no_pulse", 64'(out_valid), 64'd0);
        end
        out_ready = 1'b0;
        txn_a(33, 1, 64, 0, "post_rst");

        // Wider output / narrower CDF instance.
        model(2048, 0, 4095, PIX_W2, eg, es, edz, esc);
        lat = 0;
        while (!in_ready_b && lat < 100) begin step(); lat++; end
        check("b_rdy", 64'(in_ready_b), 64'd1);
        in_valid_b = 1'b1; cdf_in_b = 12'd2048; cdf_min_b = 12'd0; num_pixels_b = 12'd4095;
        step();
        in_valid_b = 1'b0;
        lat = 1;
        while (!out_valid_b && lat < 200) begin step(); lat++; end
        check("b_lat", 64'(lat), 64'(NUM_W2 + 1));
        check("b_g", 64'(g_out_b), 64'(eg));
        check("b_sat", 64'(sat_b), 64'd0);
        check("b_dz", 64'(div_zero_b), 64'd0);
        step();

        for (int i = 0; i < 40; i++) begin
            np = $urandom_range(1, 3000);
            sel = $urandom_range(0, 7);
            if (sel == 0) cmin = np;
            else if (sel == 1) cmin = np + $urandom_range(1, 5);
            else cmin = $urandom_range(0, 40);
            cin = $urandom_range(0, np + 100);
            txn_a(cin, cmin, np, $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
